// File: rtl/fsm_pkg.sv
// Shared definitions for the FSM vector sequencer: FSM state codes,
// sequencer states and bit positions inside stimulus/expected/result words.
package fsm_pkg;

  localparam logic [2:0] S_I8 = 3'd0;
  localparam logic [2:0] S_Z4 = 3'd1;
  localparam logic [2:0] S_P6 = 3'd2;
  localparam logic [2:0] S_F3 = 3'd3;
  localparam logic [2:0] S_K5 = 3'd4;
  localparam logic [2:0] S_Z6 = 3'd5;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  // Stimulus word {A0,A4,I3}
  localparam int VEC_W  = 3;
  localparam int VEC_A0 = 2;
  localparam int VEC_A4 = 1;
  localparam int VEC_I3 = 0;

  // Expected/result word {state[2:0],U4,U8,O3}
  localparam int RES_W      = 6;
  localparam int RES_ST_LSB = 3;
  localparam int RES_U4     = 2;
  localparam int RES_U8     = 1;
  localparam int RES_O3     = 0;

  // Stored entry is {vec, exp}
  localparam int ENTRY_W = VEC_W + RES_W;

  function automatic logic [RES_W-1:0] pack_result(input logic [2:0] st,
                                                   input logic u4,
                                                   input logic u8,
                                                   input logic o3);
    return {st, u4, u8, o3};
  endfunction

endpackage

// File: rtl/seq_ram.sv
// Vector/expected store plus the captured-result array. Both read ports are
// combinational because the FSM inputs must follow the run index in the same cycle.
module seq_ram
  import fsm_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [ENTRY_W-1:0] o_rd_data,
  input  logic               i_res_we,
  input  logic [AW-1:0]      i_res_addr,
  input  logic [RES_W-1:0]   i_res_data,
  input  logic [AW-1:0]      i_res_rd_addr,
  output logic [RES_W-1:0]   o_res_rd_data
);

  logic [ENTRY_W-1:0] r_entry [DEPTH];
  logic [RES_W-1:0]   r_res   [DEPTH];

  // The list itself survives reset; only the count in the top forgets it.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_entry[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_res[k] <= '0;
      end
    end else if (i_res_we) begin
      r_res[i_res_addr] <= i_res_data;
    end
  end

  assign o_rd_data     = r_entry[i_rd_addr];
  assign o_res_rd_data = r_res[i_res_rd_addr];

endmodule

// File: rtl/fsm_vec_sequencer.sv
// Replays a loaded vector list into the external Mealy FSM one vector per clock,
// captures state/outputs each cycle and scores them against expected words.
module fsm_vec_sequencer
  import fsm_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [VEC_W-1:0] wr_vec,
  input  logic [RES_W-1:0] wr_exp,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW:0]      fail_cnt,
  output logic [AW-1:0]    first_fail,
  output logic             overflow,
  output logic [AW:0]      count,
  input  logic [AW-1:0]    rd_addr,
  output logic [RES_W-1:0] rd_data,
  output logic             fsm_a0,
  output logic             fsm_a4,
  output logic             fsm_i3,
  output logic             fsm_rst_b,
  input  logic             fsm_u4,
  input  logic             fsm_u8,
  input  logic             fsm_o3,
  input  logic [2:0]       fsm_state
);

  seq_state_t r_state, w_state_next;

  logic [AW:0]          r_count;
  logic [AW-1:0]        r_idx;
  logic [AW:0]          r_fail_cnt;
  logic [AW-1:0]        r_first_fail;
  logic                 r_pass;
  logic                 r_overflow;

  logic [ENTRY_W-1:0]   w_entry;
  logic [VEC_W-1:0]     w_vec;
  logic [RES_W-1:0]     w_exp;
  logic [RES_W-1:0]     w_capture;
  logic                 w_mismatch;
  logic                 w_last;
  logic                 w_full;
  logic                 w_wr_accept;
  logic                 w_running;

  assign w_vec      = w_entry[ENTRY_W-1 -: VEC_W];
  assign w_exp      = w_entry[RES_W-1:0];
  assign w_capture  = pack_result(fsm_state, fsm_u4, fsm_u8, fsm_o3);
  assign w_mismatch = (w_capture != w_exp);
  assign w_last     = ({1'b0, r_idx} == (r_count - 1'b1));
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_running  = (r_state == SEQ_RUN);

  // start and clr both take priority over a write issued in the same cycle.
  assign w_wr_accept = (r_state == SEQ_IDLE) && wr_en && !start && !clr && !w_full;

  seq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk           (clk),
    .rst           (rst),
    .i_wr_en       (w_wr_accept),
    .i_wr_addr     (r_count[AW-1:0]),
    .i_wr_data     ({wr_vec, wr_exp}),
    .i_rd_addr     (r_idx),
    .o_rd_data     (w_entry),
    .i_res_we      (w_running),
    .i_res_addr    (r_idx),
    .i_res_data    (w_capture),
    .i_res_rd_addr (rd_addr),
    .o_res_rd_data (rd_data)
  );

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    fsm_rst_b    = 1'b0;
    fsm_a0       = 1'b0;
    fsm_a4       = 1'b0;
    fsm_i3       = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (start) begin
          w_state_next = (r_count == '0) ? SEQ_DONE : SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        busy      = 1'b1;
        fsm_rst_b = 1'b1;
        fsm_a0    = w_vec[VEC_A0];
        fsm_a4    = w_vec[VEC_A4];
        fsm_i3    = w_vec[VEC_I3];
        if (w_last) begin
          w_state_next = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        done         = 1'b1;
        w_state_next = SEQ_IDLE;
      end
      default: w_state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SEQ_IDLE;
      r_count      <= '0;
      r_idx        <= '0;
      r_fail_cnt   <= '0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        SEQ_IDLE: begin
          if (start) begin
            r_idx        <= '0;
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
            if (r_count == '0) begin
              r_pass <= 1'b1;
            end
          end else if (clr) begin
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
          end else if (wr_en) begin
            if (w_full) begin
              r_overflow <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        SEQ_RUN: begin
          r_idx <= r_idx + 1'b1;
          if (w_mismatch) begin
            r_fail_cnt <= r_fail_cnt + 1'b1;
            if (r_fail_cnt == '0) begin
              r_first_fail <= r_idx;
            end
          end
          // pass is settled on the last compare so it is valid alongside done.
          if (w_last) begin
            r_pass <= !w_mismatch && (r_fail_cnt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign pass       = r_pass;
  assign fail_cnt   = r_fail_cnt;
  assign first_fail = r_first_fail;
  assign overflow   = r_overflow;
  assign count      = r_count;

endmodule

// File: tb/tb_fsm_vec_sequencer.sv
// Randomized bench for fsm_vec_sequencer with a behavioural FSM stand-in and a
// list-level reference model of loading, running, scoring and readback.
module tb_fsm_vec_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst, clr, wr_en, start;
  logic [2:0]    wr_vec;
  logic [5:0]    wr_exp;
  logic [AW-1:0] rd_addr;
  logic          busy, done, pass, overflow;
  logic [AW:0]   fail_cnt, count;
  logic [AW-1:0] first_fail;
  logic [5:0]    rd_data;
  logic          fsm_a0, fsm_a4, fsm_i3, fsm_rst_b;
  logic          fsm_u4, fsm_u8, fsm_o3;
  logic [2:0]    fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fsm_vec_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_vec(wr_vec), .wr_exp(wr_exp),
    .start(start), .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .first_fail(first_fail), .overflow(overflow), .count(count), .rd_addr(rd_addr),
    .rd_data(rd_data), .fsm_a0(fsm_a0), .fsm_a4(fsm_a4), .fsm_i3(fsm_i3),
    .fsm_rst_b(fsm_rst_b), .fsm_u4(fsm_u4), .fsm_u8(fsm_u8), .fsm_o3(fsm_o3),
    .fsm_state(fsm_state)
  );

  // Stand-in 6-state Mealy FSM: next = (s + vec + 1) mod 6, outputs = (vec + 3s) mod 8.
  function automatic logic [2:0] ref_next(input logic [2:0] s, input logic [2:0] v);
    return 3'((int'(s) + int'(v) + 1) % 6);
  endfunction
  function automatic logic [2:0] ref_out(input logic [2:0] s, input logic [2:0] v);
    return 3'((int'(v) + 3 * int'(s)) % 8);
  endfunction

  logic [2:0] fsm_in;
  assign fsm_in = {fsm_a0, fsm_a4, fsm_i3};
  assign {fsm_u4, fsm_u8, fsm_o3} = ref_out(fsm_state, fsm_in);
  always_ff @(posedge clk) begin
    if (!(fsm_rst_b && !rst)) fsm_state <= 3'd0;
    else                      fsm_state <= ref_next(fsm_state, fsm_in);
  end

  // Reference model of the sequencer's visible state.
  int         m_count, m_fail, m_first;
  logic       m_overflow, m_pass;
  logic [2:0] m_vec [DEPTH];
  logic [5:0] m_exp [DEPTH];
  logic [5:0] m_res [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_count = 0; m_fail = 0; m_first = 0; m_overflow = 1'b0; m_pass = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_res[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    model_reset();
    $display("reset");
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    m_count = 0; m_overflow = 1'b0; m_pass = 1'b0; m_fail = 0; m_first = 0;
    $display("clr");
  endtask

  task automatic write_entry(input logic [2:0] v, input logic [5:0] e);
    wr_en = 1'b1; wr_vec = v; wr_exp = e;
    cycle();
    wr_en = 1'b0;
    if (m_count < DEPTH) begin
      m_vec[m_count] = v; m_exp[m_count] = e; m_count++;
    end else begin
      m_overflow = 1'b1;
    end
    $display("write vec=%b exp=%b count=%0d overflow=%0b", v, e, count, overflow);
  endtask

  // Loads n entries; expected words are the true FSM response, some corrupted.
  task automatic load_list(input int n, input bit corrupt);
    logic [2:0] s, v;
    logic [5:0] e;
    s = 3'd0;
    for (int i = 0; i < n; i++) begin
      v = 3'($urandom_range(0, 7));
      e = {s, ref_out(s, v)};
      if (corrupt && $urandom_range(0, 2) == 0) e = e ^ 6'($urandom_range(1, 63));
      s = ref_next(s, v);
      write_entry(v, e);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".count"}, 32'(count), 32'(m_count));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_overflow));
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".done"}, 32'(done), 32'd0);
    check_eq({tag, ".fsm_rst_b"}, 32'(fsm_rst_b), 32'd0);
    check_eq({tag, ".fsm_in"}, 32'(fsm_in), 32'd0);
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i);
      #1;
      check_eq($sformatf("%s.rd%0d", tag, i), 32'(rd_data), 32'(m_res[i]));
    end
  endtask

  task automatic run(input string tag, input bit noisy, input bit with_wr);
    logic [2:0] s;
    int cycles;
    s = 3'd0; m_fail = 0; m_first = 0;
    for (int i = 0; i < m_count; i++) begin
      m_res[i] = {s, ref_out(s, m_vec[i])};
      if (m_res[i] != m_exp[i]) begin
        if (m_fail == 0) m_first = i;
        m_fail++;
      end
      s = ref_next(s, m_vec[i]);
    end
    m_pass = (m_fail == 0);

    start = 1'b1; wr_en = with_wr; wr_vec = 3'($urandom); wr_exp = 6'($urandom);
    cycle();
    start = 1'b0; wr_en = 1'b0;
    cycles = 0;
    while (busy && cycles <= 2 * DEPTH) begin
      check_eq({tag, ".rst_b"}, 32'(fsm_rst_b), 32'd1);
      if (cycles < m_count) check_eq($sformatf("%s.vec%0d", tag, cycles), 32'(fsm_in), 32'(m_vec[cycles]));
      if (noisy) begin
        start = 1'($urandom); wr_en = 1'($urandom); clr = 1'($urandom);
      end
      cycles++;
      cycle();
      start = 1'b0; wr_en = 1'b0; clr = 1'b0;
    end
    check_eq({tag, ".len"}, 32'(cycles), 32'(m_count));
    check_eq({tag, ".done"}, 32'(done), 32'd1);
    check_eq({tag, ".done_rst_b"}, 32'(fsm_rst_b), 32'd0);
    check_eq({tag, ".pass"}, 32'(pass), 32'(m_pass));
    check_eq({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
    check_eq({tag, ".first_fail"}, 32'(first_fail), 32'(m_first));
    $display("run %s len=%0d pass=%0b fail_cnt=%0d first_fail=%0d", tag, cycles, pass, fail_cnt, first_fail);
    cycle();
    check_idle({tag, ".after"});
    check_results(tag);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; start = 1'b0;
    wr_vec = '0; wr_exp = '0; rd_addr = '0;
    cycle();
    do_reset();
    check_idle("rst");
    check_eq("rst.pass", 32'(pass), 32'd0);
    check_eq("rst.fail_cnt", 32'(fail_cnt), 32'd0);
    check_eq("rst.first_fail", 32'(first_fail), 32'd0);
    check_results("rst");

    // Randomized runs, with a rerun of one list to confirm it reproduces.
    for (int r = 0; r < 6; r++) begin
      do_clr();
      load_list($urandom_range(1, DEPTH), 1'b1);
      run($sformatf("rand%0d", r), 1'b1, 1'b0);
      if (r == 0) run("rerun", 1'b0, 1'b0);
    end

    // Overflow and clear.
    do_clr();
    load_list(DEPTH + 1, 1'b0);
    check_idle("ovf");
    do_clr();
    check_idle("ovf_clr");
    check_eq("ovf_clr.pass", 32'(pass), 32'd0);

    // Empty list completes immediately with pass set.
    run("empty", 1'b0, 1'b0);

    // start beats a same-cycle write.
    load_list(2, 1'b0);
    run("start_wr", 1'b1, 1'b1);

    // Reset in the middle of a 5-entry run.
    do_clr();
    load_list(5, 1'b1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    model_reset();
    check_idle("midrst");
    check_eq("midrst.fail_cnt", 32'(fail_cnt), 32'd0);
    check_results("midrst");
    cycle();
    check_eq("midrst.no_done", 32'(done), 32'd0);
    check_eq("midrst.no_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
